// File: rtl/i2s_codec_tx.sv
// I2S transmitter for the CS4272: derives MCLK/SCLK/LRCLK/RSTn from an 11-bit counter and shifts the pair out.
// Latency: a pair written before a frame starts is sent in that frame; the producer is never stalled, and underrun repeats the last pair.
module i2s_codec_tx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              RST_n,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
    input  logic              wrt,
    output logic              sample_req,
    output logic              undr,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              RSTn,
    output logic              SDin
);

    localparam int PAD = 31 - DATA_W;

    logic [10:0]       cnt_q, cnt_d;
    logic              rstn_q, rstn_d;
    logic              pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              sample_req_q, sample_req_d;
    logic              undr_q, undr_d;

    logic sfall, ld_l, ld_r;

    assign sfall = (cnt_q[4:0] == 5'h1F);
    assign ld_l  = (cnt_q == 11'h7FF);
    assign ld_r  = (cnt_q == 11'h3FF);

    always_comb begin
        cnt_d        = cnt_q + 11'd1;
        rstn_d       = rstn_q | ld_l;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        act_l_d      = act_l_q;
        act_r_d      = act_r_q;
        shreg_d      = shreg_q;
        pend_vld_d   = wrt | (pend_vld_q & ~ld_l);
        sample_req_d = ld_l;
        undr_d       = ld_l & ~pend_vld_q;

        if (wrt) begin
            pend_l_d = lft_in;
            pend_r_d = rht_in;
        end

        // Leading zero in each load provides the one-SCLK I2S delay.
        if (ld_l) begin
            if (pend_vld_q) begin
                act_l_d = pend_l_q;
                act_r_d = pend_r_q;
                shreg_d = {1'b0, pend_l_q, {PAD{1'b0}}};
            end else begin
                shreg_d = {1'b0, act_l_q, {PAD{1'b0}}};
            end
        end else if (ld_r) begin
            shreg_d = {1'b0, act_r_q, {PAD{1'b0}}};
        end else if (sfall) begin
            shreg_d = {shreg_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q        <= '0;
            rstn_q       <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            act_l_q      <= '0;
            act_r_q      <= '0;
            shreg_q      <= '0;
            sample_req_q <= 1'b0;
            undr_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rstn_q       <= rstn_d;
            pend_vld_q   <= pend_vld_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            act_l_q      <= act_l_d;
            act_r_q      <= act_r_d;
            shreg_q      <= shreg_d;
            sample_req_q <= sample_req_d;
            undr_q       <= undr_d;
        end
    end

    assign MCLK       = cnt_q[1];
    assign SCLK       = cnt_q[4];
    assign LRCLK      = cnt_q[10];
    assign RSTn       = rstn_q;
    assign SDin       = shreg_q[31] & rstn_q;
    assign sample_req = sample_req_q;
    assign undr       = undr_q;

endmodule

// File: tb/tb_i2s_codec_tx.sv
// Randomized bench for i2s_codec_tx against a frame-level reference model.
module tb_i2s_codec_tx;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          RST_n = 1'b0;
    logic [W-1:0]  lft_in = '0;
    logic [W-1:0]  rht_in = '0;
    logic          wrt = 1'b0;
    logic          sample_req, undr, MCLK, SCLK, LRCLK, RSTn, SDin;

    i2s_codec_tx #(.DATA_W(W)) dut (
        .clk(clk), .RST_n(RST_n), .lft_in(lft_in), .rht_in(rht_in), .wrt(wrt),
        .sample_req(sample_req), .undr(undr), .MCLK(MCLK), .SCLK(SCLK),
        .LRCLK(LRCLK), .RSTn(RSTn), .SDin(SDin)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time since reset release plus the pair bookkeeping of frames.
    int         t = 0;
    bit         started = 0;
    bit         pend_v = 0;
    bit         undr_flag = 0;
    logic [W-1:0] pend_l = '0, pend_r = '0, act_l = '0, act_r = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0; started = 0; pend_v = 0; undr_flag = 0;
        pend_l = '0; pend_r = '0; act_l = '0; act_r = '0;
    endtask

    task automatic model_edge(input bit w, input logic [W-1:0] l, input logic [W-1:0] r);
        if (t % 2048 == 2047) begin
            started = 1;
            if (pend_v) begin
                act_l = pend_l; act_r = pend_r; undr_flag = 0;
            end else begin
                undr_flag = 1;
            end
            pend_v = 0;
        end
        if (w) begin
            pend_l = l; pend_r = r; pend_v = 1;
        end
        t++;
    endtask

    task automatic check_all();
        int c, s;
        logic [W-1:0] v;
        logic e_sd;
        c = t % 2048;
        s = (c % 1024) / 32;
        v = (c >= 1024) ? act_r : act_l;
        e_sd = 1'b0;
        if (started && s >= 1 && s <= W) e_sd = v[W-s];
        chk("MCLK", {31'b0, MCLK}, (c >> 1) & 1);
        chk("SCLK", {31'b0, SCLK}, (c >> 4) & 1);
        chk("LRCLK", {31'b0, LRCLK}, (c >> 10) & 1);
        chk("RSTn", {31'b0, RSTn}, {31'b0, started});
        chk("sample_req", {31'b0, sample_req}, {31'b0, started && c == 0});
        chk("undr", {31'b0, undr}, {31'b0, started && c == 0 && undr_flag});
        chk("SDin", {31'b0, SDin}, {31'b0, e_sd});
    endtask

    task automatic cycle(input bit w, input logic [W-1:0] l, input logic [W-1:0] r);
        wrt = w; lft_in = l; rht_in = r;
        @(posedge clk);
        model_edge(w, l, r);
        @(negedge clk);
        wrt = 1'b0;
        check_all();
    endtask

    task automatic idle_to(input int target);
        while (t % 2048 != target) cycle(0, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_MCLK"}, {31'b0, MCLK}, 0);
        chk({tag, "_SCLK"}, {31'b0, SCLK}, 0);
        chk({tag, "_LRCLK"}, {31'b0, LRCLK}, 0);
        chk({tag, "_RSTn"}, {31'b0, RSTn}, 0);
        chk({tag, "_SDin"}, {31'b0, SDin}, 0);
        chk({tag, "_undr"}, {31'b0, undr}, 0);
        chk({tag, "_req"}, {31'b0, sample_req}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("rst");
        RST_n = 1'b1;
        model_reset();

        // Pair written early in the pre-RSTn frame, then idle frames that repeat it.
        idle(99);
        cycle(1, 16'hA5C3, 16'h1234);
        idle_to(0);
        idle_to(0);

        // One pair followed by three frames with no writes.
        idle(300);
        cycle(1, 16'h7FFF, 16'h8000);
        idle_to(0);
        idle_to(0);
        idle_to(0);
        idle_to(0);

        // Two writes in one frame: only the latest is sent.
        idle(200);
        cycle(1, 16'h1111, 16'h2222);
        idle(500);
        cycle(1, 16'h3333, 16'h4444);
        idle_to(0);
        idle_to(0);

        // Write on the frame-boundary cycle with a pair already pending.
        idle(400);
        cycle(1, 16'h0F0F, 16'hF0F0);
        idle_to(2047);
        cycle(1, 16'h5555, 16'h6666);
        idle_to(0);
        idle_to(0);

        // Random writes at random times; some frames underrun, some double-write.
        for (int i = 0; i < 6 * 2048; i++) begin
            if ($urandom_range(0, 1499) == 0)
                cycle(1, W'($urandom), W'($urandom));
            else
                cycle(0, '0, '0);
        end
        idle_to(0);

        // Asynchronous reset in the middle of a left half.
        cycle(1, 16'hBEEF, 16'hCAFE);
        idle_to(0);
        idle_to(16'h200);
        RST_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (3) @(negedge clk);
        check_zero("midrst_hold");
        RST_n = 1'b1;
        model_reset();
        idle_to(0);
        idle_to(0);
        idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
